// File: rtl/pc_gen.sv
// Fetch-stage program counter: BOOT/RUN/HALT control, trap > redirect > sequential
// next-PC selection with misaligned-target rejection. Optional return-address stack under PC_RAS_EN.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_inc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  input  logic            resume,
  output logic            halted,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr,
  input  logic            call_hint,
  input  logic            ret_hint,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);
  localparam int ALB = $clog2(INC);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;

  logic active, accept;
  logic trap_ok, trap_bad, redir_ok, redir_bad;

  assign fetch_valid   = (state_q == S_RUN);
  assign halted        = (state_q == S_HALT);
  assign pc            = pc_q;
  assign pc_plus_inc   = pc_q + XLEN'(INC);
  assign misalign      = mis_q;
  assign misalign_addr = mis_addr_q;

  assign active    = (state_q != S_BOOT);
  assign accept    = fetch_valid & fetch_ready;
  assign trap_ok   = active & trap_valid & (trap_vector[ALB-1:0] == '0);
  assign trap_bad  = active & trap_valid & (trap_vector[ALB-1:0] != '0);
  assign redir_ok  = active & redirect_valid & (redirect_pc[ALB-1:0] == '0);
  assign redir_bad = active & redirect_valid & (redirect_pc[ALB-1:0] != '0);

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;

    if (trap_ok)       pc_d = trap_vector;
    else if (redir_ok) pc_d = redirect_pc;
    else if (accept)   pc_d = pc_plus_inc;

    // A rejected trap is the one reported even if the redirect is also bad.
    if (trap_bad) begin
      mis_d      = 1'b1;
      mis_addr_d = trap_vector;
    end else if (!trap_ok && redir_bad) begin
      mis_d      = 1'b1;
      mis_addr_d = redirect_pc;
    end

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (halt_req) state_d = S_HALT;
      S_HALT:  if (resume || trap_ok || redir_ok) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [RAS_DEPTH-1:0][XLEN-1:0] ras_q, ras_d;
  logic [PW-1:0]                  top_q, top_d;
  logic [CW-1:0]                  cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(RAS_DEPTH - 1) : p - 1'b1;
  endfunction

  // Pop before push so a combined call+ret replaces the top entry.
  always_comb begin
    ras_d = ras_q;
    top_d = top_q;
    cnt_d = cnt_q;
    if (trap_ok) begin
      cnt_d = '0;
    end else if (accept) begin
      if (ret_hint && cnt_q != '0) begin
        top_d = ptr_dec(top_q);
        cnt_d = cnt_q - 1'b1;
      end
      if (call_hint) begin
        top_d        = ptr_inc(top_d);
        ras_d[top_d] = pc_plus_inc;
        if (cnt_d != CW'(RAS_DEPTH)) cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_q <= '0;
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      ras_q <= ras_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  assign ras_valid = (cnt_q != '0);
  assign ras_top   = ras_valid ? ras_q[top_q] : '0;
`else
  logic unused_hints;
  assign unused_hints = call_hint ^ ret_hint;
  assign ras_top      = '0;
  assign ras_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios then random traffic, checked against a
// cycle-level behavioural model (mode/pc/misalign/return-stack as plain variables and a queue).
module tb_pc_gen;
  localparam int XLEN = 32;
  localparam int INC  = 4;
  localparam int RASD = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_valid, fetch_ready;
  logic [XLEN-1:0] pc, pc_plus_inc;
  logic            redirect_valid, trap_valid, halt_req, resume;
  logic [XLEN-1:0] redirect_pc, trap_vector;
  logic            halted, misalign;
  logic [XLEN-1:0] misalign_addr, ras_top;
  logic            call_hint, ret_hint, ras_valid;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR('0), .INC(INC), .RAS_DEPTH(RASD)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .pc(pc), .pc_plus_inc(pc_plus_inc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_valid(trap_valid), .trap_vector(trap_vector),
    .halt_req(halt_req), .resume(resume), .halted(halted), .misalign(misalign),
    .misalign_addr(misalign_addr), .call_hint(call_hint), .ret_hint(ret_hint),
    .ras_top(ras_top), .ras_valid(ras_valid)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model: 0 = boot, 1 = run, 2 = halt
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_mis_addr;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fetch_valid", 32'(fetch_valid), 32'(m_mode == 1));
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("pc", pc, m_pc);
    chk("pc_plus_inc", pc_plus_inc, m_pc + INC);
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("misalign_addr", misalign_addr, m_mis_addr);
    chk("ras_valid", 32'(ras_valid), 32'(m_ras.size() != 0));
    chk("ras_top", ras_top, (m_ras.size() != 0) ? m_ras[$] : 32'h0);
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_mis = 0; m_mis_addr = 0;
    m_ras.delete();
  endtask

  // One clock: drive inputs, step model with the spec's rules, compare after the edge.
  task automatic cyc(input logic f = 1'b1, input logic r = 1'b0, input logic [31:0] rpc = 0,
                     input logic t = 1'b0, input logic [31:0] tvec = 0, input logic h = 1'b0,
                     input logic s = 1'b0, input logic c = 1'b0, input logic rt = 1'b0);
    bit act, acc, t_ok, r_ok;
    logic [31:0] n_pc, ret;
    int n_mode;
    fetch_ready = f; redirect_valid = r; redirect_pc = rpc; trap_valid = t;
    trap_vector = tvec; halt_req = h; resume = s; call_hint = c; ret_hint = rt;

    act  = (m_mode != 0);
    acc  = (m_mode == 1) && f;
    t_ok = act && t && (tvec % INC == 0);
    r_ok = act && r && (rpc % INC == 0);
    ret  = m_pc + INC;
    n_pc = t_ok ? tvec : r_ok ? rpc : acc ? m_pc + INC : m_pc;

    m_mis = 0;
    if (act && t && !t_ok) begin m_mis = 1; m_mis_addr = tvec; end
    else if (!t_ok && act && r && !r_ok) begin m_mis = 1; m_mis_addr = rpc; end

    if (m_mode == 0) n_mode = 1;
    else if (m_mode == 1) n_mode = h ? 2 : 1;
    else n_mode = (s || t_ok || r_ok) ? 1 : 2;

`ifdef PC_RAS_EN
    if (t_ok) m_ras.delete();
    else if (acc) begin
      if (rt && m_ras.size() != 0) void'(m_ras.pop_back());
      if (c) begin
        m_ras.push_back(ret);
        if (m_ras.size() > RASD) void'(m_ras.pop_front());
      end
    end
`endif

    @(posedge clk);
    #1;
    m_pc = n_pc;
    m_mode = n_mode;
    check_all();
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    fetch_ready = 0; redirect_valid = 0; redirect_pc = 0; trap_valid = 0; trap_vector = 0;
    halt_req = 0; resume = 0; call_hint = 0; ret_hint = 0;
    #2;
    model_reset();
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);

    // BOOT lasts one clock, then sequential fetch
    cyc();
    chk("boot_pc", pc, 32'h0);
    chk("boot_fv", 32'(fetch_valid), 32'h1);
    repeat (4) cyc();
    chk("seq_pc", pc, 32'h10);

    // Stall holds pc with request still valid
    repeat (3) begin
      cyc(1'b0);
      chk("stall_pc", pc, 32'h10);
      chk("stall_fv", 32'(fetch_valid), 32'h1);
    end

    // Trap beats redirect
    cyc(1'b1, 1'b1, 32'h200, 1'b1, 32'h100);
    chk("trap_prio", pc, 32'h100);

    // Misaligned redirect falls through to sequential
    cyc(1'b1, 1'b1, 32'h202);
    chk("mis_pc", pc, 32'h104);
    chk("mis_pulse", 32'(misalign), 32'h1);
    chk("mis_addr", misalign_addr, 32'h202);
    cyc(1'b0);
    chk("mis_clear", 32'(misalign), 32'h0);
    chk("mis_hold", misalign_addr, 32'h202);

    // Halt on accept at 0x20, then resume
    cyc(1'b1, 1'b1, 32'h1C);
    cyc();
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
    chk("halt_pc", pc, 32'h24);
    chk("halted", 32'(halted), 32'h1);
    cyc(1'b1, 1'b1, 32'h302);
    chk("halt_mis_stay", 32'(halted), 32'h1);
    chk("halt_mis_pc", pc, 32'h24);
    cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
    chk("resume_fv", 32'(fetch_valid), 32'h1);
    chk("resume_pc", pc, 32'h24);
    cyc();
    chk("resume_adv", pc, 32'h28);

    // Wrap at top of address space
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("pinc_wrap", pc_plus_inc, 32'h0);
    cyc();
    chk("wrap_pc", pc, 32'h0);

    // Return-address stack: 5 calls into a 4-deep stack, then drain
    cyc(1'b0, 1'b1, 32'h0);
    repeat (5) cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
`ifdef PC_RAS_EN
    begin
      logic [31:0] exp_ret[4];
      exp_ret = '{32'h14, 32'h10, 32'hC, 32'h8};
      for (int i = 0; i < 4; i++) begin
        chk("ras_pop_top", ras_top, exp_ret[i]);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      chk("ras_empty", 32'(ras_valid), 32'h0);
    end
`else
    chk("ras_off_valid", 32'(ras_valid), 32'h0);
    chk("ras_off_top", ras_top, 32'h0);
`endif

    // Random traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rp, tv;
      if (i == 250) do_reset();
      rp = $urandom & 32'h0000_FFFE;
      tv = $urandom & 32'h0000_FFFE;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rp,
          $urandom_range(0, 15) == 0, tv, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
